// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters, with a held response.
// Build option ALU_ARB_FIXED_PRIO_EN: requester 0 always wins simultaneous requests.
//
// state | meaning
// IDLE  | waiting for a request; grants and latches operands on accept
// EXEC  | registered operands drive the ALU for one cycle; result captured at the edge
// RESP  | response held for the granted requester until its rsp ready
module alu_share_arbiter #(
  parameter int WIDTH = 64,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             grant_q;
  logic             last_grant_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [OPW-1:0]   op_q;

  logic             sel;
  logic             accept;
  logic             retire;
  logic             sel_legal;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic [OPW-1:0]   sel_op;

  function automatic logic op_legal(input logic [OPW-1:0] op);
    logic ok;
    ok = 1'b0;
    case (op)
      4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1100: ok = 1'b1;
      default:                                     ok = 1'b0;
    endcase
    return ok;
  endfunction

  always_comb begin
    sel = 1'b0;
    if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      sel = 1'b0;
`else
      sel = ~last_grant_q;
`endif
    end else if (req1_valid) begin
      sel = 1'b1;
    end
  end

  assign sel_a     = sel ? req1_a  : req0_a;
  assign sel_b     = sel ? req1_b  : req0_b;
  assign sel_op    = sel ? req1_op : req0_op;
  assign sel_legal = op_legal(sel_op);
  assign accept    = (state_q == IDLE) && (req0_valid || req1_valid);
  assign retire    = (state_q == RESP) && (grant_q ? rsp1_ready : rsp0_ready);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    case (state_q)
      IDLE: begin
        req0_ready = accept && !sel;
        req1_ready = accept && sel;
        if (accept) state_d = sel_legal ? EXEC : RESP;
      end
      EXEC: state_d = RESP;
      RESP: begin
        rsp0_valid = !grant_q;
        rsp1_valid = grant_q;
        if (retire) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Illegal ops skip EXEC and respond with a zeroed, flagged result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      rsp_result   <= '0;
      rsp_zero     <= 1'b0;
      rsp_err      <= 1'b0;
    end else begin
      if (accept) begin
        grant_q <= sel;
        a_q     <= sel_a;
        b_q     <= sel_b;
        op_q    <= sel_op;
        if (!sel_legal) begin
          rsp_result <= '0;
          rsp_zero   <= 1'b0;
          rsp_err    <= 1'b1;
        end
      end
      if (state_q == EXEC) begin
        rsp_result <= alu_result;
        rsp_zero   <= alu_zero;
        rsp_err    <= 1'b0;
      end
      if (retire) begin
        last_grant_q <= grant_q;
      end
    end
  end

  assign alu_a  = a_q;
  assign alu_b  = b_q;
  assign alu_op = op_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU model on the alu_* side.
module tb_alu_share_arbiter;

  localparam int WIDTH = 64;
  localparam int OPW   = 4;

  logic             clk;
  logic             reset_n;
  logic             req0_valid, req0_ready;
  logic [WIDTH-1:0] req0_a, req0_b;
  logic [OPW-1:0]   req0_op;
  logic             req1_valid, req1_ready;
  logic [WIDTH-1:0] req1_a, req1_b;
  logic [OPW-1:0]   req1_op;
  logic             rsp0_valid, rsp0_ready;
  logic             rsp1_valid, rsp1_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zero, rsp_err;
  logic [WIDTH-1:0] alu_a, alu_b;
  logic [OPW-1:0]   alu_op;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  alu_share_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );

  // Illegal codes return a marker so a result leaking through the error path is visible.
  always_comb begin
    case (alu_op)
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      4'b0010: alu_result = alu_a + alu_b;
      4'b0110: alu_result = alu_a - alu_b;
      4'b1100: alu_result = ~(alu_a | alu_b);
      default: alu_result = 64'hDEAD_BEEF;
    endcase
    alu_zero = (alu_result == '0);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic retire(input int who);
    if (who == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
    tick();
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
  endtask

  initial begin
    int n0, n1, exp_g;
    logic [63:0] exp_r;

    reset_n = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    #12;
    chk("reset_req0_ready", req0_ready, 0);
    chk("reset_rsp0_valid", rsp0_valid, 0);
    chk("reset_rsp1_valid", rsp1_valid, 0);
    chk("reset_rsp_err", rsp_err, 0);
    chk("reset_rsp_result", rsp_result, 0);
    chk("reset_alu_a", alu_a, 0);
    chk("reset_alu_op", alu_op, 0);
    reset_n = 1'b1;
    tick();

    // ADD 5+7 from requester 0
    req0_valid = 1'b1; req0_a = 5; req0_b = 7; req0_op = 4'b0010;
    #1;
    chk("add_req0_ready", req0_ready, 1);
    chk("add_req1_ready", req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    chk("add_exec_ready", req0_ready, 0);
    chk("add_exec_rsp0", rsp0_valid, 0);
    chk("add_exec_alu_a", alu_a, 5);
    tick();
    chk("add_rsp0_valid", rsp0_valid, 1);
    chk("add_rsp1_valid", rsp1_valid, 0);
    chk("add_result", rsp_result, 12);
    chk("add_zero", rsp_zero, 0);
    chk("add_err", rsp_err, 0);
    retire(0);
    chk("add_retired", rsp0_valid, 0);

    // SUB 7-7 from requester 1
    req1_valid = 1'b1; req1_a = 7; req1_b = 7; req1_op = 4'b0110;
    #1;
    chk("sub_req1_ready", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    tick();
    chk("sub_rsp1_valid", rsp1_valid, 1);
    chk("sub_rsp0_valid", rsp0_valid, 0);
    chk("sub_result", rsp_result, 0);
    chk("sub_zero", rsp_zero, 1);
    retire(1);

    // Both requesters valid continuously, four ops each
    n0 = 0; n1 = 0;
    req0_valid = 1'b1; req0_a = 100; req0_b = 1;  req0_op = 4'b0010;
    req1_valid = 1'b1; req1_a = 50;  req1_b = 10; req1_op = 4'b0110;
    for (int i = 0; i < 8; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      exp_g = (i < 4) ? 0 : 1;
`else
      exp_g = i % 2;
`endif
      #1;
      chk("rr_req0_ready", req0_ready, (exp_g == 0));
      chk("rr_req1_ready", req1_ready, (exp_g == 1));
      exp_r = (exp_g == 0) ? 64'(101 + n0) : 64'(40 + n1);
      tick();
      if (exp_g == 0) begin
        n0++;
        req0_a = 64'(100 + n0);
        if (n0 == 4) req0_valid = 1'b0;
      end else begin
        n1++;
        req1_a = 64'(50 + n1);
        if (n1 == 4) req1_valid = 1'b0;
      end
      tick();
      chk("rr_rsp0_valid", rsp0_valid, (exp_g == 0));
      chk("rr_rsp1_valid", rsp1_valid, (exp_g == 1));
      chk("rr_result", rsp_result, exp_r);
      chk("rr_no_grant_in_resp", {req0_ready, req1_ready}, 0);
      retire(exp_g);
    end
    chk("rr_count0", n0, 4);
    chk("rr_count1", n1, 4);

    // AND with a 5-cycle response stall while requester 1 waits
    req0_valid = 1'b1; req0_a = 64'hFF00; req0_b = 64'h0FF0; req0_op = 4'b0000;
    #1;
    chk("and_req0_ready", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 1; req1_b = 2; req1_op = 4'b0001;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("stall_rsp0_valid", rsp0_valid, 1);
      chk("stall_result", rsp_result, 64'h0F00);
      chk("stall_req1_ready", req1_ready, 0);
      tick();
    end
    rsp0_ready = 1'b1;
    #1;
    chk("retire_req1_ready", req1_ready, 0);
    tick();
    rsp0_ready = 1'b0;
    chk("idle_rsp0_valid", rsp0_valid, 0);
    chk("idle_req1_ready", req1_ready, 1);
    req1_valid = 1'b0;
    tick();
    tick();
    chk("withdraw_rsp1_valid", rsp1_valid, 0);
    chk("withdraw_alu_a", alu_a, 64'hFF00);

    // Illegal op on requester 1, then a legal one
    req1_valid = 1'b1; req1_a = 9; req1_b = 9; req1_op = 4'b0011;
    #1;
    chk("ill_req1_ready", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    chk("ill_rsp1_valid", rsp1_valid, 1);
    chk("ill_err", rsp_err, 1);
    chk("ill_result", rsp_result, 0);
    chk("ill_zero", rsp_zero, 0);
    retire(1);
    req1_valid = 1'b1; req1_a = 64'hF0; req1_b = 64'h0F; req1_op = 4'b0001;
    tick();
    req1_valid = 1'b0;
    chk("or_exec_rsp1", rsp1_valid, 0);
    tick();
    chk("or_rsp1_valid", rsp1_valid, 1);
    chk("or_err", rsp_err, 0);
    chk("or_result", rsp_result, 64'hFF);
    retire(1);

    // Requester 0 op leaves last_grant=0, then requester 1 op is aborted by reset in EXEC
    req0_valid = 1'b1; req0_a = 1; req0_b = 1; req0_op = 4'b0010;
    tick();
    req0_valid = 1'b0;
    tick();
    chk("pre_rst_result", rsp_result, 2);
    retire(0);
    req1_valid = 1'b1; req1_a = 3; req1_b = 4; req1_op = 4'b0010;
    tick();
    req1_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("abort_rsp0_valid", rsp0_valid, 0);
    chk("abort_rsp1_valid", rsp1_valid, 0);
    chk("abort_result", rsp_result, 0);
    #2;
    reset_n = 1'b1;
    tick();
    tick();
    chk("post_rst_rsp1_valid", rsp1_valid, 0);
    req0_valid = 1'b1; req0_a = 20; req0_b = 22; req0_op = 4'b0010;
    req1_valid = 1'b1; req1_a = 30; req1_b = 5;  req1_op = 4'b0110;
    #1;
    chk("post_rst_req0_wins", req0_ready, 1);
    chk("post_rst_req1_waits", req1_ready, 0);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    chk("post_rst_rsp0_valid", rsp0_valid, 1);
    chk("post_rst_result", rsp_result, 42);
    retire(0);
    chk("post_rst_idle", {rsp0_valid, rsp1_valid}, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
